// File: rtl/tile_matmul_sequencer.sv
// rtl/tile_matmul_sequencer.sv - tiled matmul step sequencer; optional TILE_SEQ_PREFETCH_EN overlaps next weight fill with compute
module tile_matmul_sequencer #(
   parameter int WIDTH_HEIGHT = 16,
   parameter int MAX_MAT_WH   = 128,
   parameter int ADDR_WIDTH   = 10,
   parameter int TILE_W       = $clog2(MAX_MAT_WH / WIDTH_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [TILE_W-1:0]     tiles_m,
   input  logic [TILE_W-1:0]     tiles_k,
   input  logic [TILE_W-1:0]     tiles_n,
   output logic                  busy,
   output logic                  done,
   output logic                  fill_fifo,
   input  logic                  mem_to_fifo_done,
   output logic                  drain_fifo,
   input  logic                  fifo_to_arr_done,
   output logic                  mmu_active,
   input  logic                  output_done,
   output logic [ADDR_WIDTH-1:0] weight_rd_addr_base,
   output logic [ADDR_WIDTH-1:0] input_rd_addr_base,
   output logic [TILE_W-1:0]     submat_m,
   output logic [TILE_W-1:0]     submat_n,
   output logic                  accum_first
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FILL,
      S_WAIT_FILL,
      S_DRAIN,
      S_WAIT_DRAIN,
      S_COMPUTE,
      S_WAIT_COMP,
      S_ADVANCE,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [TILE_W-1:0] cnt_m, cnt_k, cnt_n;
   logic [TILE_W-1:0] m, n, k;
   logic [TILE_W-1:0] m_step, n_step, k_step;
   logic [TILE_W-1:0] w_k, w_n;
   logic              last_step;
   logic              comp_ok;
   logic              prefetch_pulse;
   logic              abort_hit;

   assign last_step = (m == cnt_m) && (n == cnt_n) && (k == cnt_k);
   assign abort_hit = abort && (state != S_IDLE);

   // next tile coordinates in m-outer, n-middle, k-inner loop order
   always_comb begin
      k_step = k + 1'b1;
      n_step = n;
      m_step = m;
      if (k == cnt_k) begin
         k_step = '0;
         n_step = n + 1'b1;
         if (n == cnt_n) begin
            n_step = '0;
            m_step = m + 1'b1;
         end
      end
   end

`ifdef TILE_SEQ_PREFETCH_EN
   logic out_seen, fill_seen;

   assign prefetch_pulse = (state == S_COMPUTE) && !last_step;
   assign comp_ok = (out_seen || output_done) && (fill_seen || mem_to_fifo_done);

   // collect compute and prefetch-fill completions in either order; last step has no prefetch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_seen  <= 1'b0;
         fill_seen <= 1'b0;
      end else if (state == S_COMPUTE) begin
         out_seen  <= 1'b0;
         fill_seen <= last_step;
      end else if (state == S_WAIT_COMP) begin
         out_seen  <= out_seen || output_done;
         fill_seen <= fill_seen || mem_to_fifo_done;
      end
   end
`else
   assign prefetch_pulse = 1'b0;
   assign comp_ok = output_done;
`endif

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic; abort overrides every completion input
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:       if (start) state_nxt = S_FILL;
         S_FILL:       state_nxt = S_WAIT_FILL;
         S_WAIT_FILL:  if (mem_to_fifo_done) state_nxt = S_DRAIN;
         S_DRAIN:      state_nxt = S_WAIT_DRAIN;
         S_WAIT_DRAIN: if (fifo_to_arr_done) state_nxt = S_COMPUTE;
         S_COMPUTE:    state_nxt = S_WAIT_COMP;
         S_WAIT_COMP:  if (comp_ok) state_nxt = S_ADVANCE;
`ifdef TILE_SEQ_PREFETCH_EN
         S_ADVANCE:    state_nxt = last_step ? S_DONE : S_DRAIN;
`else
         S_ADVANCE:    state_nxt = last_step ? S_DONE : S_FILL;
`endif
         S_DONE:       state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
      if (abort_hit) state_nxt = S_IDLE;
   end

   // latched tile counts and m/n/k step counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_m <= '0;
         cnt_k <= '0;
         cnt_n <= '0;
         m     <= '0;
         n     <= '0;
         k     <= '0;
      end else if (abort_hit) begin
         m <= '0;
         n <= '0;
         k <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt_m <= tiles_m;
                  cnt_k <= tiles_k;
                  cnt_n <= tiles_n;
                  m     <= '0;
                  n     <= '0;
                  k     <= '0;
               end
            end
            S_ADVANCE: begin
               if (last_step) begin
                  m <= '0;
                  n <= '0;
                  k <= '0;
               end else begin
                  m <= m_step;
                  n <= n_step;
                  k <= k_step;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy       = (state != S_IDLE) && (state != S_DONE);
   assign done       = (state == S_DONE);
   assign fill_fifo  = (state == S_FILL) || prefetch_pulse;
   assign drain_fifo = (state == S_DRAIN);
   assign mmu_active = (state == S_COMPUTE);

   assign submat_m    = m;
   assign submat_n    = n;
   assign accum_first = busy && (k == '0);

   // during a prefetch pulse the weight base already points at the next step
   assign w_k = prefetch_pulse ? k_step : k;
   assign w_n = prefetch_pulse ? n_step : n;

   assign weight_rd_addr_base =
      ADDR_WIDTH'((32'(w_k) * (32'(cnt_n) + 32'd1) + 32'(w_n)) * WIDTH_HEIGHT);
   assign input_rd_addr_base =
      ADDR_WIDTH'((32'(m) * (32'(cnt_k) + 32'd1) + 32'(k)) * WIDTH_HEIGHT);

endmodule

// File: tb/tb_tile_matmul_sequencer.sv
// tb/tb_tile_matmul_sequencer.sv - scoreboard bench for tile_matmul_sequencer
module tb_tile_matmul_sequencer;
   localparam int WH = 16;
   localparam int AW = 10;
   localparam int TW = 3;

   typedef struct {
      int m;
      int n;
      int k;
   } step_t;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [TW-1:0] tiles_m = '0, tiles_k = '0, tiles_n = '0;
   logic busy, done, fill_fifo, drain_fifo, mmu_active, accum_first;
   logic md_r = 1'b0, ad_r = 1'b0, od_r = 1'b0, stray_od = 1'b0;
   logic [AW-1:0] weight_rd_addr_base, input_rd_addr_base;
   logic [TW-1:0] submat_m, submat_n;

   int checks = 0, errors = 0;
   int cyc = 0, start_c = -100, last_md = -100, last_ad = -100, last_od = -100;
   int n_fill = 0, n_drain = 0, n_mmu = 0, n_done = 0;
   int n_steps = 0, cur_tn = 0, cur_tk = 0;
   int fill_dly_f = 0, drain_dly_f = 0, comp_dly_f = 0;
   bit first_fill = 1'b0, expect_done = 1'b0;
   logic busy_prev = 1'b0;
   step_t exp_q[$];

   tile_matmul_sequencer dut (
      .clk                 (clk),
      .reset               (rst_n),
      .start               (start),
      .abort               (abort),
      .tiles_m             (tiles_m),
      .tiles_k             (tiles_k),
      .tiles_n             (tiles_n),
      .busy                (busy),
      .done                (done),
      .fill_fifo           (fill_fifo),
      .mem_to_fifo_done    (md_r),
      .drain_fifo          (drain_fifo),
      .fifo_to_arr_done    (ad_r),
      .mmu_active          (mmu_active),
      .output_done         (od_r | stray_od),
      .weight_rd_addr_base (weight_rd_addr_base),
      .input_rd_addr_base  (input_rd_addr_base),
      .submat_m            (submat_m),
      .submat_n            (submat_n),
      .accum_first         (accum_first)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // datapath stand-ins: each completion returns d cycles after its request
   always begin : resp_fill
      int d;
      @(posedge clk); #1;
      if (fill_fifo) begin
         d = (fill_dly_f != 0) ? fill_dly_f : int'($urandom_range(1, 4));
         repeat (d + 1) @(negedge clk);
         md_r = 1'b1;
         @(negedge clk);
         md_r = 1'b0;
      end
   end

   always begin : resp_drain
      int d;
      @(posedge clk); #1;
      if (drain_fifo) begin
         d = (drain_dly_f != 0) ? drain_dly_f : int'($urandom_range(1, 4));
         repeat (d + 1) @(negedge clk);
         ad_r = 1'b1;
         @(negedge clk);
         ad_r = 1'b0;
      end
   end

   always begin : resp_comp
      int d;
      @(posedge clk); #1;
      if (mmu_active) begin
         d = (comp_dly_f != 0) ? comp_dly_f : int'($urandom_range(1, 5));
         repeat (d + 1) @(negedge clk);
         od_r = 1'b1;
         @(negedge clk);
         od_r = 1'b0;
      end
   end

   // monitor: inputs taken at the edge, outputs 1 ns later; pops the scoreboard on each compute pulse
   always begin : monitor
      logic st_s, md_s, ad_s, od_s;
      step_t s;
      int wk, wn;
      @(posedge clk);
      st_s = start; md_s = md_r; ad_s = ad_r; od_s = od_r;
      #1;
      cyc++;
      if (md_s) last_md = cyc - 1;
      if (ad_s) last_ad = cyc - 1;
      if (od_s) last_od = cyc - 1;
      if (rst_n && st_s && !busy_prev) begin
         start_c = cyc - 1; first_fill = 1'b1;
         n_fill = 0; n_drain = 0; n_mmu = 0;
      end
      if (mmu_active) begin
         n_mmu++;
         chk_eq("mmu_after_arr_done", cyc, last_ad + 1);
         if (exp_q.size() == 0) chk_eq("mmu_unexpected_step", exp_q.size(), 1);
         else begin
            s = exp_q.pop_front();
            chk_eq("submat_m", int'(submat_m), s.m);
            chk_eq("submat_n", int'(submat_n), s.n);
            chk_eq("input_base", int'(input_rd_addr_base), ((s.m * (cur_tk + 1) + s.k) * WH) % 1024);
            wk = s.k; wn = s.n;
`ifdef TILE_SEQ_PREFETCH_EN
            if (exp_q.size() > 0) begin wk = exp_q[0].k; wn = exp_q[0].n; end
`endif
            chk_eq("weight_base", int'(weight_rd_addr_base), ((wk * (cur_tn + 1) + wn) * WH) % 1024);
            chk_eq("accum_first", int'(accum_first), int'(s.k == 0));
            chk_eq("busy_in_step", int'(busy), 1);
         end
      end
      if (fill_fifo) begin
         n_fill++;
         if (first_fill) begin
            chk_eq("fill_after_start", cyc, start_c + 1);
            first_fill = 1'b0;
         end
`ifndef TILE_SEQ_PREFETCH_EN
         else chk_eq("fill_after_output_done", cyc, last_od + 2);
`endif
         if (!mmu_active && exp_q.size() > 0) begin
            chk_eq("fill_submat_m", int'(submat_m), exp_q[0].m);
            chk_eq("fill_submat_n", int'(submat_n), exp_q[0].n);
         end
      end
      if (drain_fifo) begin
         n_drain++;
`ifndef TILE_SEQ_PREFETCH_EN
         chk_eq("drain_after_fill_done", cyc, last_md + 1);
`endif
      end
      if (done) begin
         n_done++;
         chk_eq("done_expected", int'(expect_done), 1);
         chk_eq("done_after_output_done", cyc, last_od + 2);
         chk_eq("done_busy_low", int'(busy), 0);
         chk_eq("steps_left", exp_q.size(), 0);
         chk_eq("fill_count", n_fill, n_steps);
         chk_eq("drain_count", n_drain, n_steps);
         chk_eq("mmu_count", n_mmu, n_steps);
      end
      busy_prev = busy;
   end

   // reference model: every (m, n, k) step in loop order m outer, n middle, k inner
   task automatic run_start(input int tm, input int tk, input int tn);
      step_t s;
      exp_q.delete();
      for (int im = 0; im <= tm; im++)
         for (int in = 0; in <= tn; in++)
            for (int ik = 0; ik <= tk; ik++) begin
               s.m = im; s.n = in; s.k = ik;
               exp_q.push_back(s);
            end
      n_steps = (tm + 1) * (tn + 1) * (tk + 1);
      cur_tn = tn; cur_tk = tk; expect_done = 1'b1;
      @(negedge clk);
      tiles_m = TW'(tm); tiles_k = TW'(tk); tiles_n = TW'(tn);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int base, i;
      base = n_done; i = 0;
      while (n_done == base && i < limit) begin @(negedge clk); i++; end
      chk_eq("done_seen", n_done - base, 1);
   endtask

   // which: 0 fill, 1 drain, 2 mmu
   task automatic wait_cnt(input int which, input int target, input int limit);
      int i, v;
      i = 0;
      v = (which == 0) ? n_fill : (which == 1) ? n_drain : n_mmu;
      while (v < target && i < limit) begin
         @(negedge clk); i++;
         v = (which == 0) ? n_fill : (which == 1) ? n_drain : n_mmu;
      end
      chk_eq("wait_count", v, target);
   endtask

   initial begin
      int tm, tk, tn, base;
      repeat (3) @(negedge clk);
      chk_eq("reset_ctrl_outputs", int'({busy, done, fill_fifo, drain_fifo, mmu_active, accum_first}), 0);
      chk_eq("reset_data_outputs", int'({weight_rd_addr_base, input_rd_addr_base, submat_m, submat_n}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("idle_busy", int'(busy), 0);

      run_start(0, 0, 0);
      wait_done(200);

      run_start(1, 1, 1);
      wait_done(1000);

      // stray start and output_done while waiting for the fill
      fill_dly_f = 6;
      run_start(1, 0, 1);
      wait_cnt(0, 1, 100);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; stray_od = 1'b1;
      @(negedge clk);
      start = 1'b0; stray_od = 1'b0;
      chk_eq("stray_busy", int'(busy), 1);
      chk_eq("stray_no_drain", int'(drain_fifo), 0);
      fill_dly_f = 0;
      wait_done(1000);

      // abort in WAIT_DRAIN of step 3, coinciding with fifo_to_arr_done
      drain_dly_f = 1;
      run_start(1, 1, 1);
      wait_cnt(1, 3, 300);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_eq("abort_busy", int'(busy), 0);
      chk_eq("abort_no_mmu", int'(mmu_active), 0);
      expect_done = 1'b0;
      drain_dly_f = 0;
      base = n_done;
      repeat (10) @(negedge clk);
      chk_eq("abort_no_done", n_done, base);
      run_start(0, 0, 1);
      wait_done(300);

      // asynchronous reset between edges during WAIT_COMP of the last step
      comp_dly_f = 6;
      run_start(1, 1, 1);
      wait_cnt(2, 8, 1000);
      @(negedge clk);
      chk_eq("pre_reset_submat_m", int'(submat_m), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("async_reset_ctrl", int'({busy, done, fill_fifo, drain_fifo, mmu_active, accum_first}), 0);
      chk_eq("async_reset_data", int'({weight_rd_addr_base, input_rd_addr_base, submat_m, submat_n}), 0);
      expect_done = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("post_reset_busy", int'(busy), 0);
      chk_eq("post_reset_fill", int'(fill_fifo), 0);
      comp_dly_f = 0;
      repeat (10) @(negedge clk);

      for (int r = 0; r < 4; r++) begin
         tm = int'($urandom_range(0, 3));
         tk = int'($urandom_range(0, 3));
         tn = int'($urandom_range(0, 3));
         run_start(tm, tk, tn);
         wait_done((tm + 1) * (tk + 1) * (tn + 1) * 60 + 100);
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
      end

      run_start(2, 7, 7);
      wait_done(192 * 60 + 100);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
